// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encoding, port ids and defaults for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select between fetch and data requesters
// Build option: MEM_ARB_RR_EN alternates on contention; otherwise the data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
`ifdef MEM_ARB_RR_EN
  input  port_t last_grant,
`endif
  output logic  any_req,
  output port_t winner
);

  always_comb begin
    any_req = i_req | d_req;
    winner  = PORT_I;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      winner = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (d_req) begin
      winner = PORT_D;
    end
`else
    if (d_req) begin
      winner = PORT_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
// Build option: MEM_ARB_RR_EN selects round-robin contention instead of data-first priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WordSize    = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                I_req,
  input  logic [WordSize-1:0] I_addr,
  output logic [WordSize-1:0] I_rdata,
  output logic                I_ready,
  input  logic                D_req,
  input  logic                D_we,
  input  logic [WordSize-1:0] D_addr,
  input  logic [WordSize-1:0] D_wdata,
  output logic [WordSize-1:0] D_rdata,
  output logic                D_ready,
  output logic [WordSize-1:0] Mem_Addr,
  output logic                Mem_rd,
  output logic                Mem_wr,
  output logic [WordSize-1:0] Mem_DIN,
  input  logic [WordSize-1:0] Mem_DOUT
);

  localparam int CntW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_CYCLES - 1);

  state_t              state;
  logic [CntW-1:0]     wait_cnt;
  port_t               grant_id;
  logic                grant_we;
  logic [WordSize-1:0] grant_addr;
  logic [WordSize-1:0] grant_wdata;
  logic                any_req;
  port_t               winner;
`ifdef MEM_ARB_RR_EN
  port_t               last_grant;
`endif

  mem_arb_pick u_pick (
    .i_req      (I_req),
    .d_req      (D_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      grant_id    <= PORT_I;
      grant_we    <= 1'b0;
      grant_addr  <= '0;
      grant_wdata <= '0;
      I_ready     <= 1'b0;
      D_ready     <= 1'b0;
      I_rdata     <= '0;
      D_rdata     <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant  <= PORT_I;
`endif
    end else begin
      I_ready <= 1'b0;
      D_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= BUSY;
            wait_cnt <= '0;
            grant_id <= winner;
`ifdef MEM_ARB_RR_EN
            last_grant <= winner;
`endif
            if (winner == PORT_D) begin
              grant_we    <= D_we;
              grant_addr  <= D_addr;
              grant_wdata <= D_wdata;
            end else begin
              grant_we    <= 1'b0;
              grant_addr  <= I_addr;
              grant_wdata <= '0;
            end
          end
        end
        BUSY: begin
          // Mem_DOUT is sampled on the last BUSY edge, while Mem_rd is still asserted.
          if (wait_cnt == LastCnt) begin
            state <= ACK;
            if (grant_id == PORT_D) begin
              D_ready <= 1'b1;
              if (!grant_we) begin
                D_rdata <= Mem_DOUT;
              end
            end else begin
              I_ready <= 1'b1;
              I_rdata <= Mem_DOUT;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Mem_rd   = 1'b0;
    Mem_wr   = 1'b0;
    Mem_Addr = '0;
    Mem_DIN  = '0;
    if (state == BUSY) begin
      Mem_rd   = ~grant_we;
      Mem_wr   = grant_we;
      Mem_Addr = grant_addr;
      Mem_DIN  = grant_wdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  localparam int W = 2;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    int          exp_cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        I_req = 1'b0;
  logic [31:0] I_addr = '0;
  logic [31:0] I_rdata;
  logic        I_ready;
  logic        D_req = 1'b0;
  logic        D_we = 1'b0;
  logic [31:0] D_addr = '0;
  logic [31:0] D_wdata = '0;
  logic [31:0] D_rdata;
  logic        D_ready;
  logic [31:0] Mem_Addr;
  logic        Mem_rd;
  logic        Mem_wr;
  logic [31:0] Mem_DIN;
  logic [31:0] Mem_DOUT;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  exp_t sb[$];

  logic [31:0] sh_i = '0;
  logic [31:0] sh_d = '0;
  bit          ref_written [256];
  logic [31:0] ref_mem [256];
  bit          written [256];
  logic [31:0] wmem [256];
  bit          exp_win [3];

  mem_arbiter #(.WordSize(32), .WAIT_CYCLES(W)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .I_req    (I_req),
    .I_addr   (I_addr),
    .I_rdata  (I_rdata),
    .I_ready  (I_ready),
    .D_req    (D_req),
    .D_we     (D_we),
    .D_addr   (D_addr),
    .D_wdata  (D_wdata),
    .D_rdata  (D_rdata),
    .D_ready  (D_ready),
    .Mem_Addr (Mem_Addr),
    .Mem_rd   (Mem_rd),
    .Mem_wr   (Mem_wr),
    .Mem_DIN  (Mem_DIN),
    .Mem_DOUT (Mem_DOUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_written[a[7:0]] ? ref_mem[a[7:0]] : pat(a[7:0]);
  endfunction

  // Behavioural memory: unwritten words return a fixed address pattern.
  always @(posedge CLK) begin
    if (Mem_wr) begin
      written[Mem_Addr[7:0]] <= 1'b1;
      wmem[Mem_Addr[7:0]]    <= Mem_DIN;
    end
  end

  always_comb begin
    Mem_DOUT = '0;
    if (Mem_rd) begin
      Mem_DOUT = written[Mem_Addr[7:0]] ? wmem[Mem_Addr[7:0]] : pat(Mem_Addr[7:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    exp_t e;
    if (we) begin
      ref_written[addr[7:0]] = 1'b1;
      ref_mem[addr[7:0]]     = wdata;
    end else if (port) begin
      sh_d = ref_rd(addr);
    end else begin
      sh_i = ref_rd(addr);
    end
    e.port    = port;
    e.we      = we;
    e.addr    = addr;
    e.wdata   = port ? wdata : '0;
    e.exp_i   = sh_i;
    e.exp_d   = sh_d;
    e.exp_cyc = cyc + 1 + W;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge CLK);
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(posedge CLK);
    #1;
    if (port) begin
      D_req = 1'b1; D_we = we; D_addr = addr; D_wdata = wdata;
    end else begin
      I_req = 1'b1; I_addr = addr;
    end
    push(port, we, addr, wdata);
    wait_done();
    I_req = 1'b0;
    D_req = 1'b0;
  endtask

  task automatic round(input int r, input bit win);
    @(posedge CLK);
    #1;
    I_req = 1'b1; I_addr = 32'h04 + r;
    D_req = 1'b1; D_we = 1'b0; D_addr = 32'h08 + r; D_wdata = '0;
    push(win, 1'b0, win ? D_addr : I_addr, '0);
    wait_done();
    I_req = 1'b0;
    D_req = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!Reset) begin
      if (Mem_rd || Mem_wr) begin
        if (Mem_wr) wr_cnt++; else rd_cnt++;
        check("rd_wr_exclusive", {31'd0, Mem_rd & Mem_wr}, 32'd0);
        if (sb.size() == 0) begin
          check("spurious_mem_access", 32'd1, 32'd0);
        end else begin
          check("mem_addr", Mem_Addr, sb[0].addr);
          check("mem_din", Mem_DIN, sb[0].wdata);
          check("mem_wr", {31'd0, Mem_wr}, {31'd0, sb[0].we});
        end
      end else begin
        check("idle_mem_addr", Mem_Addr, 32'd0);
        check("idle_mem_din", Mem_DIN, 32'd0);
      end
      if (I_ready || D_ready) begin
        if (sb.size() == 0) begin
          check("spurious_ready", {30'd0, I_ready, D_ready}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ready_i", {31'd0, I_ready}, {31'd0, !e.port});
          check("ready_d", {31'd0, D_ready}, {31'd0, e.port});
          check("latency_cycle", cyc, e.exp_cyc);
          check("i_rdata", I_rdata, e.exp_i);
          check("d_rdata", D_rdata, e.exp_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int r0;
`ifdef MEM_ARB_RR_EN
    exp_win = '{1'b1, 1'b0, 1'b1};
`else
    exp_win = '{1'b1, 1'b1, 1'b1};
`endif
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;
    check("rst_strobes", {28'd0, Mem_rd, Mem_wr, I_ready, D_ready}, 32'd0);
    check("rst_mem_addr", Mem_Addr, 32'd0);
    check("rst_i_rdata", I_rdata, 32'd0);
    check("rst_d_rdata", D_rdata, 32'd0);

    for (int r = 0; r < 3; r++) round(r, exp_win[r]);

    w0 = wr_cnt;
    r0 = rd_cnt;
    access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    check("write_wr_cycles", wr_cnt - w0, W);
    check("write_rd_cycles", rd_cnt - r0, 0);

    access(1'b0, 1'b0, 32'h10, '0);
    check("fetch_after_write", I_rdata, 32'hDEADBEEF);

    // Address/data/we change and req drops right after the grant edge.
    @(posedge CLK);
    #1;
    D_req = 1'b1; D_we = 1'b1; D_addr = 32'h20; D_wdata = 32'h12345678;
    push(1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge CLK);
    #1;
    D_addr = 32'h40; D_wdata = 32'hBADBAD00; D_we = 1'b0; D_req = 1'b0;
    wait_done();
    check("landed_orig_addr", wmem[8'h20], 32'h12345678);
    check("no_write_new_addr", {31'd0, written[8'h40]}, 32'd0);
    access(1'b1, 1'b0, 32'h20, '0);
    access(1'b1, 1'b0, 32'h40, '0);

    @(posedge CLK);
    #1;
    I_req = 1'b1; I_addr = 32'h30;
    push(1'b0, 1'b0, 32'h30, '0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    I_req = 1'b0;
    sb.delete();
    sh_i = '0;
    sh_d = '0;
    check("abort_strobes", {28'd0, Mem_rd, Mem_wr, I_ready, D_ready}, 32'd0);
    check("abort_mem_addr", Mem_Addr, 32'd0);
    check("abort_i_rdata", I_rdata, 32'd0);
    check("abort_d_rdata", D_rdata, 32'd0);
    repeat (6) @(posedge CLK);

    round(3, 1'b1);
    access(1'b0, 1'b0, 32'h30, '0);
    access(1'b1, 1'b1, 32'h50, 32'hCAFEF00D);
    access(1'b0, 1'b0, 32'h50, '0);

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
